capture_ram: RTL and testbench

- Parametrised successor to the 512x8 sample RAM: a circular, multi-channel capture buffer with pre-/post-trigger control.
- Writes samples continuously into a ring of 2^ADDR_W entries and stops a programmable number of samples after a qualified trigger.
- Host reads back the buffer in chronological order, oldest sample first.
- Sits between the ADC sample front end/trigger logic and the command/readout UART path.

---
 rtl/capture_ram.sv | 219 +++++++++++++++++++++
 tb/tb_capture_ram.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/capture_ram.sv
// capture_ram: circular multi-channel capture buffer with pre-/post-trigger control.
//
// Samples are written continuously into a ring of DEPTH = 2^ADDR_W entries.
// A qualified trigger (trig together with smpl_en while ARMED) freezes the
// ring P = trig_pos samples later. After that, the host reads the buffer back
// in chronological order: rd_addr 0 is the oldest sample and DEPTH-1-P is the
// trigger sample.
//
// Optional build macro CAPTURE_RAM_RDREG_EN adds an output register after the
// RAM read, which makes the read latency 2 instead of 1.
//
// Handshake: a read is accepted on any rclk edge where rd_en is high, the
// block is in DONE and start is low. rd_valid is then high for exactly one
// cycle, 1 (or 2) cycles later, and rd_data holds the word during that cycle.
// rd_data keeps its value until the next accepted read completes.
//
// dbg_state exposes the FSM state: 0 IDLE, 1 PRETRIG, 2 ARMED, 3 POSTTRIG, 4 DONE.

module capture_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 9,
    parameter int NUM_CH = 1
) (
    input  logic                       rclk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       smpl_en,
    input  logic [NUM_CH*DATA_W-1:0]   smpl_data,
    input  logic                       trig,
    input  logic [ADDR_W-1:0]          trig_pos,
    output logic                       busy,
    output logic                       capture_done,
    output logic [ADDR_W-1:0]          trig_addr,
    input  logic                       rd_en,
    input  logic [ADDR_W-1:0]          rd_addr,
    output logic [NUM_CH*DATA_W-1:0]   rd_data,
    output logic                       rd_valid,
    output logic [2:0]                 dbg_state
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int W     = NUM_CH * DATA_W;

    // Highest index in the ring, DEPTH-1, in pointer width and in count width.
    localparam logic [ADDR_W-1:0] LAST_IDX = '1;
    localparam logic [ADDR_W:0]   CNT_LAST = {1'b0, LAST_IDX};

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PRETRIG  = 3'd1,
        S_ARMED    = 3'd2,
        S_POSTTRIG = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    // Sample storage: one write port (capture side), one read port (host side).
    logic [W-1:0] mem [DEPTH];

    state_t            state_q,     state_d;
    logic [ADDR_W-1:0] wptr_q,      wptr_d;
    logic [ADDR_W:0]   cnt_q,       cnt_d;
    logic [ADDR_W-1:0] p_lat_q,     p_lat_d;
    logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
    logic              busy_q,      busy_d;
    logic              done_q,      done_d;
    logic [W-1:0]      rd_data_q,   rd_data_d;
    logic              rd_valid_q,  rd_valid_d;
`ifdef CAPTURE_RAM_RDREG_EN
    logic [W-1:0]      ram_q,       ram_d;
    logic              ram_v_q,     ram_v_d;
`endif

    logic              wr_en;
    logic              rd_fire;
    logic [ADDR_W:0]   cnt_inc;
    logic [ADDR_W:0]   pre_thr;
    logic [ADDR_W-1:0] rd_phys;

    // The pre-trigger fill length is DEPTH-1-P. The count is one bit wider
    // than the pointer so that DEPTH-1 never wraps.
    assign cnt_inc = cnt_q + 1'b1;
    assign pre_thr = CNT_LAST - {1'b0, p_lat_q};

    // In DONE the oldest sample sits at the physical write pointer.
    assign rd_phys = wptr_q + rd_addr;

    // Capture FSM next state, pointer and counter updates.
    always_comb begin
        state_d     = state_q;
        wptr_d      = wptr_q;
        cnt_d       = cnt_q;
        p_lat_d     = p_lat_q;
        trig_addr_d = trig_addr_q;
        wr_en       = 1'b0;
        rd_fire     = 1'b0;

        if (start) begin
            // start wins in every state. It aborts any capture and drops a
            // same-cycle read. A zero-length fill (P = DEPTH-1) goes straight
            // to ARMED.
            wptr_d  = '0;
            cnt_d   = '0;
            p_lat_d = trig_pos;
            state_d = (trig_pos == LAST_IDX) ? S_ARMED : S_PRETRIG;
        end else begin
            case (state_q)
                S_PRETRIG: begin
                    if (smpl_en) begin
                        wr_en  = 1'b1;
                        wptr_d = wptr_q + 1'b1;
                        cnt_d  = cnt_inc;
                        if (cnt_inc == pre_thr) begin
                            state_d = S_ARMED;
                        end
                    end
                end
                S_ARMED: begin
                    if (smpl_en) begin
                        wr_en  = 1'b1;
                        wptr_d = wptr_q + 1'b1;
                        if (trig) begin
                            cnt_d = '0;
                            if (p_lat_q == '0) begin
                                state_d     = S_DONE;
                                trig_addr_d = LAST_IDX - p_lat_q;
                            end else begin
                                state_d = S_POSTTRIG;
                            end
                        end
                    end
                end
                S_POSTTRIG: begin
                    if (smpl_en) begin
                        wr_en  = 1'b1;
                        wptr_d = wptr_q + 1'b1;
                        cnt_d  = cnt_inc;
                        if (cnt_inc == {1'b0, p_lat_q}) begin
                            state_d     = S_DONE;
                            trig_addr_d = LAST_IDX - p_lat_q;
                        end
                    end
                end
                S_DONE: begin
                    rd_fire = rd_en;
                end
                default: begin
                end
            endcase
        end
    end

    // Status outputs are registered from the next state, so they line up with state_q.
    always_comb begin
        busy_d = (state_d == S_PRETRIG) || (state_d == S_ARMED) ||
                 (state_d == S_POSTTRIG);
        done_d = (state_d == S_DONE);
    end

    // Read path: synchronous RAM read, optionally followed by a second stage.
    always_comb begin
`ifdef CAPTURE_RAM_RDREG_EN
        ram_d      = rd_fire ? mem[rd_phys] : ram_q;
        ram_v_d    = rd_fire;
        rd_data_d  = ram_v_q ? ram_q : rd_data_q;
        rd_valid_d = ram_v_q;
`else
        rd_data_d  = rd_fire ? mem[rd_phys] : rd_data_q;
        rd_valid_d = rd_fire;
`endif
    end

    // Sample write port. The RAM has no reset, so its contents survive rst_n.
    always_ff @(posedge rclk) begin
        if (wr_en) begin
            mem[wptr_q] <= smpl_data;
        end
    end

    // All control and output registers, async active-low reset.
    always_ff @(posedge rclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            wptr_q      <= '0;
            cnt_q       <= '0;
            p_lat_q     <= '0;
            trig_addr_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
`ifdef CAPTURE_RAM_RDREG_EN
            ram_q       <= '0;
            ram_v_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            wptr_q      <= wptr_d;
            cnt_q       <= cnt_d;
            p_lat_q     <= p_lat_d;
            trig_addr_q <= trig_addr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
`ifdef CAPTURE_RAM_RDREG_EN
            ram_q       <= ram_d;
            ram_v_q     <= ram_v_d;
`endif
        end
    end

    assign busy         = busy_q;
    assign capture_done = done_q;
    assign trig_addr    = trig_addr_q;
    assign rd_data      = rd_data_q;
    assign rd_valid     = rd_valid_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_capture_ram.sv
// tb_capture_ram: self-checking bench for capture_ram with a 16-entry ring.
// It uses table-driven read vectors, a read scoreboard and hand-written
// sequences for restart, reset, trigger-ignore and read-gating corners.

module tb_capture_ram;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int NUM_CH = 1;
    localparam int W      = DATA_W * NUM_CH;
    localparam int DEPTH  = 16;
`ifdef CAPTURE_RAM_RDREG_EN
    localparam int RD_LAT = 2;
`else
    localparam int RD_LAT = 1;
`endif

    logic              rclk      = 1'b0;
    logic              rst_n     = 1'b0;
    logic              start     = 1'b0;
    logic              smpl_en   = 1'b0;
    logic [W-1:0]      smpl_data = '0;
    logic              trig      = 1'b0;
    logic [ADDR_W-1:0] trig_pos  = '0;
    logic              rd_en     = 1'b0;
    logic [ADDR_W-1:0] rd_addr   = '0;
    logic              busy;
    logic              capture_done;
    logic [ADDR_W-1:0] trig_addr;
    logic [W-1:0]      rd_data;
    logic              rd_valid;
    logic [2:0]        dbg_state;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q[$];   // scoreboard: expected read data in issue order
    logic [W-1:0] hist[$];    // every sample written since the last start
    logic [W-1:0] last_rd;    // most recent expected rd_data value

    typedef struct {
        logic [ADDR_W-1:0] idx;
        logic [W-1:0]      exp;
    } rd_vec_t;
    rd_vec_t vecs[6];

    capture_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_CH(NUM_CH)) dut (
        .rclk(rclk), .rst_n(rst_n), .start(start), .smpl_en(smpl_en),
        .smpl_data(smpl_data), .trig(trig), .trig_pos(trig_pos),
        .busy(busy), .capture_done(capture_done), .trig_addr(trig_addr),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_valid(rd_valid), .dbg_state(dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 rclk = ~rclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_start(input logic [ADDR_W-1:0] p);
        start    = 1'b1;
        trig_pos = p;
        tick();
        start    = 1'b0;
        hist.delete();
    endtask

    // One sample strobe, preceded by 0..1 idle cycles to vary the strobe spacing.
    task automatic sample(input logic [W-1:0] d, input logic t);
        repeat ($urandom_range(0, 1)) tick();
        smpl_en   = 1'b1;
        smpl_data = d;
        trig      = t;
        tick();
        smpl_en   = 1'b0;
        trig      = 1'b0;
        hist.push_back(d);
    endtask

    // A single read with an exact latency and pulse-width check.
    task automatic read_one(input logic [ADDR_W-1:0] idx, input logic [W-1:0] exp);
        rd_en   = 1'b1;
        rd_addr = idx;
        tick();
        rd_en   = 1'b0;
        for (int c = 1; c <= RD_LAT; c++) begin
            check("rd_valid_latency", rd_valid, (c == RD_LAT));
            if (c == RD_LAT) check("rd_data_single", rd_data, exp);
            else tick();
        end
        last_rd = exp;
        tick();
        check("rd_valid_pulse", rd_valid, 1'b0);
    endtask

    // Back-to-back reads of every index. Expectations come from the sample history.
    task automatic read_burst();
        for (int i = 0; i < DEPTH; i++) begin
            rd_en   = 1'b1;
            rd_addr = ADDR_W'(i);
            exp_q.push_back(hist[hist.size() - DEPTH + i]);
            tick();
            if (rd_valid) sb_pop();
        end
        rd_en = 1'b0;
        for (int k = 0; k < RD_LAT + 2 && exp_q.size() > 0; k++) begin
            if (rd_valid) sb_pop();
            if (exp_q.size() > 0) tick();
        end
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL rd_burst_timeout: %0d reads outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic sb_pop();
        logic [W-1:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rd_unexpected: rd_valid with data 0x%0h, expected none", rd_data);
        end else begin
            e = exp_q.pop_front();
            check("rd_burst_data", rd_data, e);
            last_rd = e;
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        vecs[0] = '{idx: 4'd0,  exp: 8'hF5};
        vecs[1] = '{idx: 4'd3,  exp: 8'hF8};
        vecs[2] = '{idx: 4'd10, exp: 8'hFF};
        vecs[3] = '{idx: 4'd11, exp: 8'h0A};
        vecs[4] = '{idx: 4'd12, exp: 8'h0B};
        vecs[5] = '{idx: 4'd15, exp: 8'h0E};

        // Reset state.
        #3;
        check("rst_busy", busy, 1'b0);
        check("rst_done", capture_done, 1'b0);
        check("rst_rd_valid", rd_valid, 1'b0);
        check("rst_rd_data", rd_data, 8'h00);
        check("rst_trig_addr", trig_addr, 4'd0);
        check("rst_state", dbg_state, 3'd0);
        @(negedge rclk);
        rst_n = 1'b1;
        tick();

        // A read in IDLE is ignored.
        rd_en = 1'b1; rd_addr = 4'd5; tick(); rd_en = 1'b0;
        for (int c = 0; c < RD_LAT; c++) begin
            check("idle_rd_valid", rd_valid, 1'b0);
            tick();
        end
        check("idle_rd_data", rd_data, 8'h00);

        // P=4. The fill is 11 samples with trig raised on fill sample 3, which
        // must be ignored. The trigger sample is 0x0A, then 0x0B..0x0E follow.
        do_start(4'd4);
        check("t1_busy", busy, 1'b1);
        for (int i = 0; i < 11; i++) begin
            sample(8'hF5 + 8'(i), (i == 3));
            check("t1_pre_busy", busy, 1'b1);
            check("t1_pre_done", capture_done, 1'b0);
        end
        sample(8'h0A, 1'b1);
        for (int i = 0; i < 4; i++) begin
            check("t1_post_done", capture_done, 1'b0);
            sample(8'h0B + 8'(i), 1'b0);
        end
        check("t1_done", capture_done, 1'b1);
        check("t1_busy_low", busy, 1'b0);
        check("t1_trig_addr", trig_addr, 4'd11);
        for (int v = 0; v < 6; v++) read_one(vecs[v].idx, vecs[v].exp);
        read_burst();

        // P=0, with extra ARMED samples so the ring wraps before the trigger.
        do_start(4'd0);
        rd_en = 1'b1; rd_addr = 4'd2; tick(); rd_en = 1'b0;
        for (int c = 0; c < RD_LAT; c++) begin
            check("pre_rd_valid", rd_valid, 1'b0);
            tick();
        end
        check("pre_rd_hold", rd_data, last_rd);
        for (int i = 0; i < 15; i++) sample(8'h20 + 8'(i), 1'b0);
        for (int i = 0; i < 5; i++) sample(8'h30 + 8'(i), 1'b0);
        check("t2_armed_busy", busy, 1'b1);
        check("t2_armed_done", capture_done, 1'b0);
        sample(8'h40, 1'b1);
        check("t2_done", capture_done, 1'b1);
        check("t2_trig_addr", trig_addr, 4'd15);
        read_one(4'd15, 8'h40);
        read_one(4'd0, 8'h25);
        read_burst();

        // P=15. The capture is armed right after start, triggers on the first
        // strobe, then takes 15 more samples.
        do_start(4'd15);
        check("t3_busy", busy, 1'b1);
        sample(8'h50, 1'b1);
        for (int i = 1; i < 16; i++) begin
            check("t3_post_done", capture_done, 1'b0);
            sample(8'h50 + 8'(i), 1'b0);
        end
        check("t3_done", capture_done, 1'b1);
        check("t3_trig_addr", trig_addr, 4'd0);
        read_one(4'd0, 8'h50);
        read_one(4'd15, 8'h5F);

        // start in DONE together with rd_en drops the read and clears capture_done.
        start = 1'b1; trig_pos = 4'd2; rd_en = 1'b1; rd_addr = 4'd3;
        tick();
        start = 1'b0; rd_en = 1'b0;
        hist.delete();
        check("t4_done_dropped", capture_done, 1'b0);
        check("t4_restart_busy", busy, 1'b1);
        for (int c = 0; c < RD_LAT; c++) begin
            check("t4_rd_dropped", rd_valid, 1'b0);
            if (c < RD_LAT - 1) tick();
        end
        check("t4_rd_hold", rd_data, last_rd);

        // Restart while in POSTTRIG, then complete a fresh P=2 capture.
        for (int i = 0; i < 13; i++) sample(8'h60 + 8'(i), 1'b0);
        sample(8'h6D, 1'b1);
        sample(8'h6E, 1'b0);
        check("t5_in_post_busy", busy, 1'b1);
        do_start(4'd2);
        check("t5_restart_done", capture_done, 1'b0);
        check("t5_restart_busy", busy, 1'b1);
        for (int i = 0; i < 13; i++) sample(8'h80 + 8'(i), 1'b0);
        sample(8'h8D, 1'b1);
        sample(8'h8E, 1'b0);
        check("t5_post_done", capture_done, 1'b0);
        sample(8'h8F, 1'b0);
        check("t5_done", capture_done, 1'b1);
        check("t5_trig_addr", trig_addr, 4'd13);
        read_burst();

        // Async reset mid-ARMED clears all outputs without a clock edge.
        do_start(4'd4);
        for (int i = 0; i < 11; i++) sample(8'hA0 + 8'(i), 1'b0);
        check("t6_armed_busy", busy, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_busy", busy, 1'b0);
        check("t6_rst_done", capture_done, 1'b0);
        check("t6_rst_trig_addr", trig_addr, 4'd0);
        check("t6_rst_rd_data", rd_data, 8'h00);
        check("t6_rst_rd_valid", rd_valid, 1'b0);
        check("t6_rst_state", dbg_state, 3'd0);
        @(negedge rclk);
        rst_n = 1'b1;
        tick();
        check("t6_idle_busy", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
